// File: rtl/conv_out_writer_pkg.sv
// Shared constants for the convolution output write-back path: FSM encoding,
// default layer geometry and the address-width helper.
package conv_out_writer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_WRITE = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    localparam int unsigned CONV_LANES = 4;
    localparam int unsigned CONV_DW    = 8;
    localparam int unsigned CONV_DEPTH = 2562;

    // Smallest address width covering every bank of one frame.
    function automatic int unsigned calc_aw(input int unsigned depth,
                                            input int unsigned pingpong);
        int unsigned words;
        int unsigned aw;
        words = depth * (pingpong + 1);
        aw    = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(words)) aw = i + 1;
        end
        return aw;
    endfunction

endpackage

// File: rtl/conv_out_addr_gen.sv
// Word counter and bank selector for one output frame; produces the banked
// BRAM address and the terminal-count flag.
module conv_out_addr_gen
    import conv_out_writer_pkg::*;
#(
    parameter int unsigned DEPTH    = CONV_DEPTH,
    parameter int unsigned AW       = 13,
    parameter int unsigned PINGPONG = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_i,
    input  logic          adv_i,
    input  logic          toggle_i,
    output logic [AW-1:0] addr_o,
    output logic          bank_o,
    output logic          last_o
);

    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] BASE1 = AW'(DEPTH);

    logic [AW-1:0] cnt_q, cnt_d;
    logic          bank_q, bank_d;

    assign last_o = (cnt_q == LAST);
    assign bank_o = bank_q;
    assign addr_o = (bank_q ? BASE1 : '0) + cnt_q;

    // Counter saturates at the last word so the address can never leave the bank.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (adv_i && !last_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        bank_d = bank_q;
        if (toggle_i && (PINGPONG != 0)) bank_d = ~bank_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            bank_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            bank_q <= bank_d;
        end
    end

endmodule

// File: rtl/conv_out_writer.sv
// Write-back stage: accepts LANES channels per beat over valid/ready and
// registers them onto a single-port BRAM write port, one frame per start.
module conv_out_writer
    import conv_out_writer_pkg::*;
#(
    parameter int unsigned LANES    = CONV_LANES,
    parameter int unsigned DW       = CONV_DW,
    parameter int unsigned DEPTH    = CONV_DEPTH,
    parameter int unsigned AW       = 13,
    parameter int unsigned PINGPONG = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                in_valid,
    input  logic [LANES*DW-1:0] in_data,
    output logic                in_ready,
    output logic                ena,
    output logic                wea,
    output logic [AW-1:0]       addra,
    output logic [LANES*DW-1:0] dina,
    output logic                bank,
    output logic                busy,
    output logic                frame_done,
    output logic                overflow
);

    if (AW < calc_aw(DEPTH, PINGPONG)) begin : g_cfg_check
        $fatal(1, "conv_out_writer: AW too small for DEPTH*(PINGPONG+1)");
    end

    state_t              state_q, state_d;
    logic                wr_q;
    logic [AW-1:0]       addra_q;
    logic [LANES*DW-1:0] dina_q;
    logic                fd_q;
    logic                ovf_q;

    logic                in_write;
    logic                accept;
    logic [AW-1:0]       gen_addr;
    logic                gen_bank;
    logic                gen_last;
    logic                ovf_event;

    assign in_write  = (state_q == ST_WRITE);
    assign accept    = in_valid && in_write;
    assign ovf_event = (in_valid && !in_write) || (start && (state_q != ST_IDLE));

    conv_out_addr_gen #(
        .DEPTH   (DEPTH),
        .AW      (AW),
        .PINGPONG(PINGPONG)
    ) u_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i ((state_q == ST_IDLE) && start),
        .adv_i   (accept),
        .toggle_i((state_q == ST_DONE) && fd_q),
        .addr_o  (gen_addr),
        .bank_o  (gen_bank),
        .last_o  (gen_last)
    );

    // DONE spans two cycles: the first lets the final BRAM write land,
    // the second carries the frame_done pulse.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_WRITE;
            ST_WRITE: if (accept && gen_last) state_d = ST_DONE;
            ST_DONE:  if (fd_q) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wr_q    <= 1'b0;
            addra_q <= '0;
            dina_q  <= '0;
            fd_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= accept;
            if (accept) begin
                addra_q <= gen_addr;
                dina_q  <= in_data;
            end
            fd_q <= (state_q == ST_DONE) && !fd_q;
            if (ovf_event) ovf_q <= 1'b1;
        end
    end

    assign in_ready   = in_write;
    assign busy       = in_write;
    assign ena        = wr_q;
    assign wea        = wr_q;
    assign addra      = addra_q;
    assign dina       = dina_q;
    assign bank       = gen_bank;
    assign frame_done = fd_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_conv_out_writer.sv
// Directed bench for conv_out_writer: a full-size ping-pong instance and a
// DEPTH=8 instance, with expected BRAM writes checked through scoreboards.
module tb_conv_out_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Instance A: DEPTH 2562, ping-pong
    logic        a_rst_n, a_start, a_valid;
    logic [31:0] a_data;
    logic        a_ready, a_ena, a_wea, a_bank, a_busy, a_fd, a_ovf;
    logic [12:0] a_addra;
    logic [31:0] a_dina;

    conv_out_writer #(
        .LANES(4), .DW(8), .DEPTH(2562), .AW(13), .PINGPONG(1)
    ) dut_a (
        .clk(clk), .rst_n(a_rst_n), .start(a_start), .in_valid(a_valid),
        .in_data(a_data), .in_ready(a_ready), .ena(a_ena), .wea(a_wea),
        .addra(a_addra), .dina(a_dina), .bank(a_bank), .busy(a_busy),
        .frame_done(a_fd), .overflow(a_ovf)
    );

    // Instance B: DEPTH 8, ping-pong
    logic        b_rst_n, b_start, b_valid;
    logic [31:0] b_data;
    logic        b_ready, b_ena, b_wea, b_bank, b_busy, b_fd, b_ovf;
    logic [3:0]  b_addra;
    logic [31:0] b_dina;

    conv_out_writer #(
        .LANES(4), .DW(8), .DEPTH(8), .AW(4), .PINGPONG(1)
    ) dut_b (
        .clk(clk), .rst_n(b_rst_n), .start(b_start), .in_valid(b_valid),
        .in_data(b_data), .in_ready(b_ready), .ena(b_ena), .wea(b_wea),
        .addra(b_addra), .dina(b_dina), .bank(b_bank), .busy(b_busy),
        .frame_done(b_fd), .overflow(b_ovf)
    );

    logic [44:0] qa[$];
    logic [35:0] qb[$];
    int a_writes = 0, a_fds = 0;
    int b_writes = 0, b_fds = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [44:0] e;
        if (a_fd) a_fds++;
        if (a_ena || a_wea) begin
            chk("a_ena_eq_wea", {63'd0, a_ena}, {63'd0, a_wea});
            a_writes++;
            vectors++;
            assert (qa.size() > 0) else begin
                miscompares++;
                $error("FAIL a_unexpected_write observed_addr=0x%0h expected=none", a_addra);
            end
            if (qa.size() > 0) begin
                e = qa.pop_front();
                chk("a_addra", 64'(a_addra), 64'(e[44:32]));
                chk("a_dina", 64'(a_dina), 64'(e[31:0]));
            end
        end
    end

    always @(negedge clk) begin
        logic [35:0] e;
        if (b_fd) b_fds++;
        if (b_ena || b_wea) begin
            chk("b_ena_eq_wea", {63'd0, b_ena}, {63'd0, b_wea});
            b_writes++;
            vectors++;
            assert (qb.size() > 0) else begin
                miscompares++;
                $error("FAIL b_unexpected_write observed_addr=0x%0h expected=none", b_addra);
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk("b_addra", 64'(b_addra), 64'(e[35:32]));
                chk("b_dina", 64'(b_dina), 64'(e[31:0]));
            end
        end
    end

    task automatic a_frame(input int unsigned base, input int unsigned seed, input logic bank_after);
        int w0, f0;
        logic [7:0] v;
        w0 = a_writes;
        f0 = a_fds;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk("a_ready_after_start", 64'(a_ready), 64'd1);
        chk("a_busy_after_start", 64'(a_busy), 64'd1);
        for (int k = 0; k < 2562; k++) begin
            v = 8'(k + int'(seed));
            a_valid = 1'b1;
            a_data  = {4{v}};
            qa.push_back({13'(base + k), {4{v}}});
            tick();
        end
        a_valid = 1'b0;
        chk("a_ready_drop", 64'(a_ready), 64'd0);
        chk("a_fd_early", 64'(a_fd), 64'd0);
        tick();
        chk("a_fd_pulse", 64'(a_fd), 64'd1);
        tick();
        chk("a_fd_clear", 64'(a_fd), 64'd0);
        chk("a_bank_after", 64'(a_bank), 64'(bank_after));
        chk("a_busy_idle", 64'(a_busy), 64'd0);
        tick();
        chk("a_queue_drained", 64'(qa.size()), 64'd0);
        chk("a_write_count", 64'(a_writes - w0), 64'd2562);
        chk("a_fd_count", 64'(a_fds - f0), 64'd1);
    endtask

    // One accepted beat on B followed by 'gap' idle cycles.
    task automatic b_beat(input logic [3:0] addr, input logic [31:0] d, input int gap, input logic st);
        b_valid = 1'b1;
        b_start = st;
        b_data  = d;
        chk("b_ready_at_beat", 64'(b_ready), 64'd1);
        qb.push_back({addr, d});
        tick();
        b_valid = 1'b0;
        b_start = 1'b0;
        for (int g = 0; g < gap; g++) tick();
    endtask

    task automatic b_reset_check(input string tag);
        chk(tag, 64'({b_ena, b_wea, b_addra, b_dina, b_bank, b_busy, b_ready, b_fd, b_ovf}), 64'd0);
    endtask

    initial begin
        int w0, f0;
        a_rst_n = 1'b0; a_start = 1'b0; a_valid = 1'b0; a_data = '0;
        b_rst_n = 1'b0; b_start = 1'b0; b_valid = 1'b0; b_data = '0;
        tick();
        tick();
        chk("a_reset_state", 64'({a_ena, a_wea, a_addra, a_dina, a_bank, a_busy, a_ready, a_fd, a_ovf}), 64'd0);
        b_reset_check("b_reset_state");
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        tick();

        // Two full ping-pong frames back to back
        a_frame(0, 0, 1'b1);
        a_frame(2562, 7, 1'b0);
        chk("a_no_overflow", 64'(a_ovf), 64'd0);

        // Beat offered in IDLE, then a gapped frame
        b_valid = 1'b1;
        b_data  = 32'hDEADBEEF;
        tick();
        b_valid = 1'b0;
        chk("b_idle_beat_overflow", 64'(b_ovf), 64'd1);
        w0 = b_writes;
        f0 = b_fds;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int k = 0; k < 8; k++) b_beat(4'(k), {4{8'(8'h10 * k + 8'h3)}}, 2, 1'b0);
        tick();
        chk("b_gap_write_count", 64'(b_writes - w0), 64'd8);
        chk("b_gap_fd_count", 64'(b_fds - f0), 64'd1);
        chk("b_gap_overflow_sticky", 64'(b_ovf), 64'd1);
        chk("b_gap_bank", 64'(b_bank), 64'd1);
        chk("b_gap_queue", 64'(qb.size()), 64'd0);

        // Start pulsed mid-frame at cnt 3
        b_rst_n = 1'b0;
        tick();
        b_rst_n = 1'b1;
        chk("b_ovf_cleared", 64'(b_ovf), 64'd0);
        w0 = b_writes;
        f0 = b_fds;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int k = 0; k < 8; k++) b_beat(4'(k), 32'h01020300 + 32'(k), 0, k == 3);
        tick();
        tick();
        tick();
        chk("b_midstart_writes", 64'(b_writes - w0), 64'd8);
        chk("b_midstart_fd_count", 64'(b_fds - f0), 64'd1);
        chk("b_midstart_overflow", 64'(b_ovf), 64'd1);
        chk("b_midstart_bank", 64'(b_bank), 64'd1);

        // Reset at cnt 5 abandons the frame
        b_rst_n = 1'b0;
        tick();
        b_rst_n = 1'b1;
        f0 = b_fds;
        w0 = b_writes;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int k = 0; k < 5; k++) b_beat(4'(k), 32'hA0A0A000 + 32'(k), 0, 1'b0);
        b_rst_n = 1'b0;
        tick();
        b_rst_n = 1'b1;
        b_reset_check("b_midframe_reset");
        tick();
        chk("b_abort_no_fd", 64'(b_fds - f0), 64'd0);
        chk("b_abort_writes", 64'(b_writes - w0), 64'd5);
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        chk("b_restart_bank", 64'(b_bank), 64'd0);
        for (int k = 0; k < 8; k++) b_beat(4'(k), 32'h5A5A5A00 + 32'(k), 0, 1'b0);
        tick();
        tick();
        tick();
        chk("b_restart_fd_count", 64'(b_fds - f0), 64'd1);
        chk("b_restart_writes", 64'(b_writes - w0), 64'd13);
        chk("b_restart_overflow", 64'(b_ovf), 64'd0);
        chk("b_final_queue", 64'(qb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
